// File: rtl/leitor_tabuleiro.sv
// Scans the 8x8 reed-switch board row by row, debounces whole frames and
// reports the square where a piece was newly placed until it is acknowledged.
module leitor_tabuleiro #(
    parameter int SCAN_CYCLES = 4,
    parameter int DEBOUNCE    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilita,
    input  logic [7:0]  colunas,
    output logic [7:0]  linhas,
    output logic [3:0]  jogadaLinha,
    output logic [3:0]  jogadaColuna,
    output logic        temJogada,
    input  logic        jogadaLida,
    output logic        multipla,
    output logic        perdida,
    output logic [2:0]  db_estado,
    output logic [63:0] db_tabuleiro
);

    localparam int CW = $clog2(SCAN_CYCLES);
    localparam int NW = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        VARRE      = 3'd1,
        FIM_QUADRO = 3'd2,
        COMMIT     = 3'd3
    } estado_t;

    estado_t        estado, proximo;
    logic [2:0]     linha;
    logic [CW-1:0]  ciclo;
    logic [NW-1:0]  cnt, cnt_prox;
    logic [63:0]    quadro, anterior, imagem, novas;
    logic [5:0]     menor;
    logic           primeiro, ultimo_ciclo, iguais, varias, pendente, commit_agora;

    assign ultimo_ciclo = (ciclo == CW'(SCAN_CYCLES - 1));
    assign iguais       = (quadro == anterior);
    assign novas        = quadro & ~imagem;
    assign varias       = |(novas & (novas - 64'd1));
    // An ack arriving together with a commit frees the slot for the new move.
    assign pendente     = temJogada & ~jogadaLida;
    assign db_estado    = estado;
    assign db_tabuleiro = imagem;

    always_comb begin
        cnt_prox = NW'(1);
        if (iguais) begin
            cnt_prox = (cnt == NW'(DEBOUNCE)) ? cnt : cnt + NW'(1);
        end
    end

    // Commit only on the frame where the count first reaches DEBOUNCE.
    assign commit_agora = (cnt_prox == NW'(DEBOUNCE)) && !(iguais && (cnt == NW'(DEBOUNCE)));

    always_comb begin
        menor = '0;
        for (int i = 63; i >= 0; i--) begin
            if (novas[i]) menor = 6'(i);
        end
    end

    always_comb begin
        linhas = '0;
        if (estado == VARRE) linhas[linha] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) estado <= INICIAL;
        else        estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        if (!habilita) begin
            proximo = INICIAL;
        end else begin
            case (estado)
                INICIAL:    proximo = VARRE;
                VARRE:      if (ultimo_ciclo && linha == 3'd7) proximo = FIM_QUADRO;
                FIM_QUADRO: proximo = commit_agora ? COMMIT : VARRE;
                COMMIT:     proximo = VARRE;
                default:    proximo = INICIAL;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            linha        <= '0;
            ciclo        <= '0;
            cnt          <= '0;
            quadro       <= '0;
            anterior     <= '0;
            imagem       <= '0;
            primeiro     <= 1'b1;
            jogadaLinha  <= '0;
            jogadaColuna <= '0;
            temJogada    <= 1'b0;
            multipla     <= 1'b0;
            perdida      <= 1'b0;
        end else begin
            if (jogadaLida && temJogada) temJogada <= 1'b0;
            if (!habilita) begin
                linha <= '0;
                ciclo <= '0;
                cnt   <= '0;
            end else begin
                case (estado)
                    INICIAL: begin
                        linha <= '0;
                        ciclo <= '0;
                    end
                    VARRE: begin
                        if (ultimo_ciclo) begin
                            quadro[{linha, 3'b000} +: 8] <= colunas;
                            ciclo <= '0;
                            linha <= linha + 3'd1;
                        end else begin
                            ciclo <= ciclo + CW'(1);
                        end
                    end
                    FIM_QUADRO: begin
                        cnt <= cnt_prox;
                        if (!iguais) anterior <= quadro;
                    end
                    COMMIT: begin
                        imagem <= quadro;
                        // The first committed image is the setup, never a move.
                        if (primeiro) begin
                            primeiro <= 1'b0;
                        end else begin
                            if (novas != '0 && !pendente) begin
                                jogadaLinha  <= {1'b0, menor[5:3]};
                                jogadaColuna <= {1'b0, menor[2:0]};
                                temJogada    <= 1'b1;
                            end
                            if (varias) multipla <= 1'b1;
                            if (novas != '0 && pendente) perdida <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_leitor_tabuleiro.sv
// Directed bench for leitor_tabuleiro: a board model drives colunas from linhas,
// each step checks state, committed image and reported move against hand values.
module tb_leitor_tabuleiro;

    localparam logic [63:0] B0  = 64'hFFFF00000000FFFF;
    localparam logic [63:0] B1  = 64'hFFFF00001000FFFF;
    localparam logic [63:0] B2  = 64'hFFFF02001020FFFF;
    localparam logic [63:0] B2M = 64'hFFFF02001020FFFE;

    logic        clock;
    logic        reset;
    logic        habilita;
    logic [7:0]  colunas;
    logic [7:0]  linhas;
    logic [3:0]  jogadaLinha;
    logic [3:0]  jogadaColuna;
    logic        temJogada;
    logic        jogadaLida;
    logic        multipla;
    logic        perdida;
    logic [2:0]  db_estado;
    logic [63:0] db_tabuleiro;
    logic [63:0] board;

    int n_assert;
    int n_fail;

    leitor_tabuleiro #(.SCAN_CYCLES(2), .DEBOUNCE(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .habilita    (habilita),
        .colunas     (colunas),
        .linhas      (linhas),
        .jogadaLinha (jogadaLinha),
        .jogadaColuna(jogadaColuna),
        .temJogada   (temJogada),
        .jogadaLida  (jogadaLida),
        .multipla    (multipla),
        .perdida     (perdida),
        .db_estado   (db_estado),
        .db_tabuleiro(db_tabuleiro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        colunas = '0;
        for (int r = 0; r < 8; r++) begin
            if (linhas[r]) colunas = colunas | board[8*r +: 8];
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_move(input string tag, input logic tem, input logic [3:0] lin, input logic [3:0] col);
        check_output({tag, "_tem"}, 64'(temJogada), 64'(tem));
        check_output({tag, "_lin"}, 64'(jogadaLinha), 64'(lin));
        check_output({tag, "_col"}, 64'(jogadaColuna), 64'(col));
    endtask

    // Called at the first cycle of a frame (VARRE, row 0, cycle 0).
    task automatic apply_frame(input logic [63:0] img, input bit commits, input bit ack_commit);
        board = img;
        step(2);
        check_output("row1_drive", 64'(linhas), 64'h02);
        step(14);
        check_output("fim_state", 64'(db_estado), 64'd2);
        check_output("fim_linhas", 64'(linhas), 64'd0);
        step(1);
        if (commits) begin
            check_output("commit_state", 64'(db_estado), 64'd3);
            if (ack_commit) jogadaLida = 1'b1;
            step(1);
            jogadaLida = 1'b0;
        end
        check_output("frame_restart", 64'(db_estado), 64'd1);
        check_output("frame_row0", 64'(linhas), 64'h01);
    endtask

    task automatic ack_frame();
        jogadaLida = 1'b1;
        step(1);
        jogadaLida = 1'b0;
        check_output("ack_clears", 64'(temJogada), 64'd0);
        step(16);
        check_output("ack_frame_end", 64'(db_estado), 64'd1);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        habilita   = 1'b1;
        jogadaLida = 1'b0;
        board      = B0;
        step(3);
        check_output("rst_state", 64'(db_estado), 64'd0);
        check_output("rst_linhas", 64'(linhas), 64'd0);
        check_output("rst_tab", db_tabuleiro, 64'd0);
        check_move("rst", 1'b0, 4'd0, 4'd0);
        check_output("rst_mult", 64'(multipla), 64'd0);
        check_output("rst_perd", 64'(perdida), 64'd0);

        // Setup board is committed after two frames but never reported.
        reset = 1'b1;
        step(1);
        check_output("start_state", 64'(db_estado), 64'd1);
        check_output("start_linhas", 64'(linhas), 64'h01);
        apply_frame(B0, 1'b0, 1'b0);
        check_output("setup_pending", db_tabuleiro, 64'd0);
        apply_frame(B0, 1'b1, 1'b0);
        check_output("setup_tab", db_tabuleiro, B0);
        check_output("setup_tem", 64'(temJogada), 64'd0);

        // Single new piece at (3,4).
        apply_frame(B1, 1'b0, 1'b0);
        check_output("p34_wait", 64'(temJogada), 64'd0);
        apply_frame(B1, 1'b1, 1'b0);
        check_move("p34", 1'b1, 4'd3, 4'd4);
        check_output("p34_tab", db_tabuleiro, B1);
        check_output("p34_mult", 64'(multipla), 64'd0);
        ack_frame();
        check_move("p34_ack", 1'b0, 4'd3, 4'd4);

        // Removal commits silently, toggling never commits, then re-placement reports.
        apply_frame(B0, 1'b0, 1'b0);
        apply_frame(B0, 1'b1, 1'b0);
        check_output("rem_tab", db_tabuleiro, B0);
        check_output("rem_tem", 64'(temJogada), 64'd0);
        for (int i = 0; i < 6; i++) apply_frame((i % 2 == 0) ? B1 : B0, 1'b0, 1'b0);
        check_output("toggle_tab", db_tabuleiro, B0);
        check_output("toggle_tem", 64'(temJogada), 64'd0);
        apply_frame(B1, 1'b0, 1'b0);
        apply_frame(B1, 1'b1, 1'b0);
        check_move("replace", 1'b1, 4'd3, 4'd4);
        ack_frame();

        // Two placements in one frame: lowest index reported, multipla set.
        apply_frame(B2, 1'b0, 1'b0);
        apply_frame(B2, 1'b1, 1'b0);
        check_move("dual", 1'b1, 4'd2, 4'd5);
        check_output("dual_mult", 64'(multipla), 64'd1);
        check_output("dual_perd", 64'(perdida), 64'd0);
        check_output("dual_tab", db_tabuleiro, B2);
        apply_frame(B2, 1'b0, 1'b0);
        check_move("dual_hold", 1'b1, 4'd2, 4'd5);

        // Removing (0,0) while a move is pending is not a lost move.
        apply_frame(B2M, 1'b0, 1'b0);
        apply_frame(B2M, 1'b1, 1'b0);
        check_output("rem00_perd", 64'(perdida), 64'd0);
        check_output("rem00_tab", db_tabuleiro, B2M);

        // Placing (0,0) with (2,5) still pending is lost.
        apply_frame(B2, 1'b0, 1'b0);
        apply_frame(B2, 1'b1, 1'b0);
        check_output("lost_perd", 64'(perdida), 64'd1);
        check_move("lost", 1'b1, 4'd2, 4'd5);
        check_output("lost_tab", db_tabuleiro, B2);

        // Ack in the commit cycle lets the new move latch.
        apply_frame(B2M, 1'b0, 1'b0);
        apply_frame(B2M, 1'b1, 1'b0);
        apply_frame(B2, 1'b0, 1'b0);
        apply_frame(B2, 1'b1, 1'b1);
        check_move("ack_commit", 1'b1, 4'd0, 4'd0);

        // Reset during row 4 clears everything at the next edge.
        step(8);
        check_output("row4_drive", 64'(linhas), 64'h10);
        reset = 1'b0;
        step(1);
        check_output("midrst_state", 64'(db_estado), 64'd0);
        check_output("midrst_linhas", 64'(linhas), 64'd0);
        check_output("midrst_tab", db_tabuleiro, 64'd0);
        check_move("midrst", 1'b0, 4'd0, 4'd0);
        check_output("midrst_mult", 64'(multipla), 64'd0);
        check_output("midrst_perd", 64'(perdida), 64'd0);
        reset = 1'b1;
        step(1);
        check_output("restart_state", 64'(db_estado), 64'd1);
        apply_frame(B0, 1'b0, 1'b0);
        apply_frame(B0, 1'b1, 1'b0);
        check_output("resetup_tab", db_tabuleiro, B0);
        check_output("resetup_tem", 64'(temJogada), 64'd0);

        // Disabling mid-frame idles the scan but keeps the committed image.
        step(5);
        habilita = 1'b0;
        step(1);
        check_output("idle_linhas", 64'(linhas), 64'd0);
        check_output("idle_state", 64'(db_estado), 64'd0);
        check_output("idle_tab", db_tabuleiro, B0);
        step(3);
        check_output("idle_stays", 64'(db_estado), 64'd0);
        habilita = 1'b1;
        step(1);
        check_output("reenable_state", 64'(db_estado), 64'd1);
        check_output("reenable_linhas", 64'(linhas), 64'h01);
        apply_frame(B0, 1'b0, 1'b0);
        apply_frame(B0, 1'b1, 1'b0);
        check_output("reenable_tab", db_tabuleiro, B0);
        check_output("reenable_tem", 64'(temJogada), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
